matrix_result_streamer: RTL and testbench
=========================================

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 8, giving the element width in bits.
REQ-002 The block SHALL have parameter MAX_DIM, default 5, giving the maximum row and column count; the matrix bus is MAX_DIM*MAX_DIM*ELEM_W = 200 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets the block immediately.
REQ-005 start  input  1  request to stream the matrix on matrix_in; sampled only in IDLE.
REQ-006 m  input  3  row count, valid range 1..5.
REQ-007 n  input  3  column count, valid range 1..5.
REQ-008 matrix_in  input  200  flattened matrix; element (i,j) at bits [(i*5+j)*8 +: 8], stride 5 regardless of n.
REQ-009 out_ready  input  1  downstream can accept one element this cycle.
REQ-010 out_valid  output  1  out_data/out_row/out_col hold a valid element.
REQ-011 out_data  output  8  current element value.
REQ-012 out_row  output  3  row index of current element.
REQ-013 out_col  output  3  column index of current element.
REQ-014 out_last  output  1  current element is (m-1,n-1).
REQ-015 busy  output  1  high in STREAM and DONE.
REQ-016 done  output  1  one-cycle pulse after the last transfer.
REQ-017 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-018 The FSM SHALL have states IDLE, STREAM, DONE.
REQ-019 IDLE + start with m,n in 1..5: capture matrix_in, m, n into internal registers; row=0, col=0; go to STREAM.
REQ-020 IDLE + start with m or n equal to 0 or greater than 5: err=1 in the next cycle for exactly one cycle; stay IDLE; out_valid stays 0.
REQ-021 Latency: start accepted at edge k gives out_valid=1 from edge k+1.
REQ-022 In STREAM, out_valid=1 and out_data=captured element (out_row,out_col).
REQ-023 A transfer occurs on an edge where out_valid=1 and out_ready=1; one element per transfer.
REQ-024 On a transfer with col<n-1: col+1; with col=n-1: col=0, row+1; order is row-major.
REQ-025 On the transfer of the element with out_last=1: go to DONE; out_valid=0 next cycle.
REQ-026 With out_valid=1 and out_ready=0, out_data, out_row, out_col, out_last SHALL hold unchanged.
REQ-027 out_valid SHALL NOT depend combinationally on out_ready.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 start SHALL be ignored in STREAM and DONE, and SHALL NOT set err there.
REQ-030 Changes on matrix_in, m, n after capture SHALL NOT affect the stream in progress.
REQ-031 With out_ready held high, m*n elements SHALL be transferred in m*n consecutive cycles.
REQ-032 out_data, out_row, out_col, out_last SHALL be 0 whenever out_valid=0.
REQ-033 Elements outside rows 0..m-1 or columns 0..n-1 SHALL never be emitted.

Reset
REQ-034 While reset=0: state=IDLE; out_valid, out_data, out_row, out_col, out_last, busy, done, err all 0; captured registers cleared.
REQ-035 Reset asserted mid-stream SHALL abort the stream immediately with no done pulse; the first start after reset deasserts is handled as in IDLE.

Verification
REQ-036 Reset: reset=0 at any time -> all outputs 0 in the same cycle, before the next clk edge.
REQ-037 m=2, n=3, elements (0,0..2)=0x11,0x12,0x13, (1,0..2)=0x21,0x22,0x23, out_ready=1 -> six beats 11,12,13,21,22,23 on cycles 1..6; out_last only on beat 6; done on cycle 7; busy cycles 1..7.
REQ-038 m=5, n=5, out_ready=1 -> 25 beats in row-major order; beat 25 carries bits [199:192] with row=4, col=4, out_last=1.
REQ-039 m=2, n=2, out_ready=0 for 3 cycles at beat 2 -> out_data/out_row/out_col hold (0,1) for 4 cycles; no beat is lost or repeated.
REQ-040 start with m=0, or with n=6 -> err pulse for one cycle, busy=0, no out_valid; a later start with m=1, n=1 -> one beat with out_last=1, then done.
REQ-041 During a 3x3 stream: pulse start and change matrix_in -> stream unaffected, no err; reset=0 at beat 4 -> out_valid=0 at once, no done pulse.

Source files
------------

// File: rtl/matrix_result_streamer_if.sv
// Handshake bundle between a matrix producer/consumer and matrix_result_streamer.
// The master side issues start/m/n/matrix_in and drives out_ready; the slave side streams elements back.
interface matrix_result_streamer_if #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_W;

  logic              start;
  logic [DIM_W-1:0]  m;
  logic [DIM_W-1:0]  n;
  logic [MAT_W-1:0]  matrix_in;
  logic              out_ready;
  logic              out_valid;
  logic [ELEM_W-1:0] out_data;
  logic [DIM_W-1:0]  out_row;
  logic [DIM_W-1:0]  out_col;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, m, n, matrix_in, out_ready,
    input  out_valid, out_data, out_row, out_col, out_last, busy, done, err
  );

  modport slave (
    input  start, m, n, matrix_in, out_ready,
    output out_valid, out_data, out_row, out_col, out_last, busy, done, err
  );
endinterface

// File: rtl/matrix_result_streamer.sv
// Captures an m x n matrix on start and streams it element by element in row-major order.
// Handshake: an element moves on a rising edge where out_valid and out_ready are both 1; out_valid never looks at out_ready.
module matrix_result_streamer #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  matrix_result_streamer_if.slave  bus,
  output logic [1:0]               state_o
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_W;
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [MAT_W-1:0]  mat_q, mat_d;
  logic [DIM_W-1:0]  m_q, m_d;
  logic [DIM_W-1:0]  n_q, n_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic              err_q, err_d;

  logic              dims_ok;
  logic              at_last;
  logic              streaming;
  logic              xfer;
  logic [ELEM_W-1:0] elem;

  assign dims_ok   = (bus.m != '0) && (bus.m <= DIM_MAX) &&
                     (bus.n != '0) && (bus.n <= DIM_MAX);
  assign at_last   = (row_q == m_q - DIM_ONE) && (col_q == n_q - DIM_ONE);
  assign streaming = (state_q == S_STREAM);
  assign xfer      = streaming && bus.out_ready;

  // The matrix keeps a fixed stride of MAX_DIM per row, independent of n.
  always_comb begin
    elem = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (row_q == DIM_W'(r) && col_q == DIM_W'(c)) begin
          elem = mat_q[(r * MAX_DIM + c) * ELEM_W +: ELEM_W];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (dims_ok) begin
            mat_d   = bus.matrix_in;
            m_d     = bus.m;
            n_d     = bus.n;
            row_d   = '0;
            col_d   = '0;
            state_d = S_STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (at_last) begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_DONE;
          end else if (col_q == n_q - DIM_ONE) begin
            col_d = '0;
            row_d = row_q + DIM_ONE;
          end else begin
            col_d = col_q + DIM_ONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mat_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end

  // Every output decodes from registers, so an asynchronous reset clears them all at once.
  assign bus.out_valid = streaming;
  assign bus.out_data  = streaming ? elem  : '0;
  assign bus.out_row   = streaming ? row_q : '0;
  assign bus.out_col   = streaming ? col_q : '0;
  assign bus.out_last  = streaming && at_last;
  assign bus.busy      = (state_q == S_STREAM) || (state_q == S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: random matrices and dimensions checked
// against a row-major expected queue built directly from the captured matrix.
module tb_matrix_result_streamer;
  localparam int ELEM_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;
  logic [14:0] exp_q[$];

  matrix_result_streamer_if #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM)) bus ();

  matrix_result_streamer #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] r;
    for (int i = 0; i < MAX_DIM * MAX_DIM; i++) r[i*ELEM_W +: ELEM_W] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic logic [11:0] outs_now();
    return {bus.out_valid, bus.out_data, bus.out_row[0], bus.out_col[0], bus.out_last, bus.err} |
           {9'b0, bus.busy, bus.done, |{bus.out_row, bus.out_col}};
  endfunction

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.m         = '0;
    bus.n         = '0;
    bus.matrix_in = '0;
    bus.out_ready = 1'b0;
  endtask

  // mode 0: out_ready always 1; mode 1: random out_ready; mode 2: 3-cycle stall on the second beat
  task automatic run_stream(input int mm, input int nn, input logic [MAT_W-1:0] mat,
                            input int mode, input bit disturb);
    int cyc, beats, stall, total;
    bit finished;
    logic rdy;
    logic [14:0] obs;
    exp_q.delete();
    for (int i = 0; i < mm; i++)
      for (int j = 0; j < nn; j++)
        exp_q.push_back({(i == mm - 1 && j == nn - 1), 3'(i), 3'(j), mat[(i*MAX_DIM + j)*ELEM_W +: ELEM_W]});
    total = mm * nn;
    @(negedge clk);
    bus.start = 1'b1; bus.m = 3'(mm); bus.n = 3'(nn); bus.matrix_in = mat; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; beats = 0; stall = 0; finished = 0;
    while (!finished && cyc < 400) begin
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL stream_err cyc=%0d got=%b exp=0", cyc, bus.err); end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL stream_busy cyc=%0d got=%b exp=1", cyc, bus.busy); end
      if (beats == total) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b1)
          begin errors++; $display("FAIL done_pulse cyc=%0d got valid=%b done=%b exp valid=0 done=1", cyc, bus.out_valid, bus.done); end
        if (mode == 0) begin
          checks++;
          if (cyc != total + 1) begin errors++; $display("FAIL done_cycle got=%0d exp=%0d", cyc, total + 1); end
        end
        finished = 1;
      end else begin
        obs = {bus.out_last, bus.out_row, bus.out_col, bus.out_data};
        checks++;
        if (bus.out_valid !== 1'b1 || obs !== exp_q[0])
          begin errors++; $display("FAIL beat cyc=%0d valid=%b got=%h exp=%h", cyc, bus.out_valid, obs, exp_q[0]); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL early_done cyc=%0d got=%b exp=0", cyc, bus.done); end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: begin rdy = !(beats == 1 && stall < 3); if (!rdy) stall++; end
        endcase
        bus.out_ready = rdy;
        if (disturb && cyc == 2) begin
          bus.start = 1'b1; bus.m = 3'($urandom_range(0, 7)); bus.n = 3'($urandom_range(0, 7));
        end else begin
          bus.start = 1'b0;
        end
        if (disturb) bus.matrix_in = rand_mat();
        if (rdy) begin void'(exp_q.pop_front()); beats++; end
      end
      @(negedge clk);
      cyc++;
    end
    if (!finished) begin errors++; $display("FAIL stream_timeout beats=%0d exp=%0d", beats, total); end
    bus.out_ready = 1'b0; bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.out_valid, bus.err, bus.out_data, bus.out_last} !== 12'b0)
      begin errors++; $display("FAIL post_idle busy=%b done=%b valid=%b err=%b data=%h exp all 0", bus.busy, bus.done, bus.out_valid, bus.err, bus.out_data); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.m = 3'd2; bus.n = 3'd2; bus.matrix_in = rand_mat();
    @(negedge clk);
    checks++;
    if (outs_now() !== 12'b0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", outs_now()); end
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_now() !== 12'b0) begin errors++; $display("FAIL reset_release got=%h exp=0", outs_now()); end
  endtask

  task automatic test_known_2x3();
    logic [MAT_W-1:0] mat;
    mat = '0;
    mat[0*8 +: 8] = 8'h11; mat[1*8 +: 8] = 8'h12; mat[2*8 +: 8] = 8'h13;
    mat[5*8 +: 8] = 8'h21; mat[6*8 +: 8] = 8'h22; mat[7*8 +: 8] = 8'h23;
    run_stream(2, 3, mat, 0, 0);
  endtask

  task automatic test_full_5x5();
    run_stream(5, 5, rand_mat(), 0, 0);
  endtask

  task automatic test_stall();
    run_stream(2, 2, rand_mat(), 2, 0);
  endtask

  task automatic test_bad_dims();
    int bad_m[4] = '{0, 2, 7, 3};
    int bad_n[4] = '{3, 6, 1, 0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.m = 3'(bad_m[k]); bus.n = 3'(bad_n[k]); bus.matrix_in = rand_mat();
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
        begin errors++; $display("FAIL err_pulse m=%0d n=%0d got err=%b busy=%b valid=%b exp 1/0/0", bad_m[k], bad_n[k], bus.err, bus.busy, bus.out_valid); end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0 || bus.out_valid !== 1'b0)
        begin errors++; $display("FAIL err_width m=%0d n=%0d got err=%b valid=%b exp 0/0", bad_m[k], bad_n[k], bus.err, bus.out_valid); end
    end
    run_stream(1, 1, rand_mat(), 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++)
      run_stream($urandom_range(1, 5), $urandom_range(1, 5), rand_mat(), 1, 1'(k % 2));
  endtask

  task automatic test_reset_mid();
    logic [MAT_W-1:0] mat;
    mat = rand_mat();
    @(negedge clk);
    bus.start = 1'b1; bus.m = 3'd3; bus.n = 3'd3; bus.matrix_in = mat; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mat[5*8 +: 8] || bus.out_row !== 3'd1 || bus.out_col !== 3'd0)
      begin errors++; $display("FAIL beat4 valid=%b data=%h row=%0d col=%0d exp 1/%h/1/0", bus.out_valid, bus.out_data, bus.out_row, bus.out_col, mat[5*8 +: 8]); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs_now() !== 12'b0) begin errors++; $display("FAIL reset_async got=%h exp=0", outs_now()); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (outs_now() !== 12'b0) begin errors++; $display("FAIL reset_hold k=%0d got=%h exp=0", k, outs_now()); end
    end
    reset = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL no_done_after_reset got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
    end
    run_stream(3, 3, rand_mat(), 0, 0);
  endtask

  initial begin
    test_reset();
    test_known_2x3();
    test_full_5x5();
    test_stall();
    test_bad_dims();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
